register_32: RTL and testbench
==============================

Name: register_32

Overview:
- 32-bit general-purpose storage register with write enable and asynchronous clear.
- Basic state element of the CPU datapath.
- Instantiated in pairs inside pipeline registers (e.g. the IF/ID stage holds instruction and PC+4), and usable for the PC and other architectural state.
- Parents connect it positionally, so port order is part of the contract.

Parameters:
- WIDTH, 32, data width in bits. All pipeline users rely on the default.
- RESET_VALUE, 32'h00000000, value loaded on reset. Truncated or zero-extended to WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high clear; forces the register to RESET_VALUE.
- out  output  WIDTH  current stored value, driven directly from flops.
- in  input  WIDTH  data to store.
- write  input  1  write enable, active-high, sampled at the rising clk edge.
- Positional order (mandatory, used by all parents): out, in, write, reset, clk.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset).
- Reset:
  - While reset=1, out = RESET_VALUE (0x00000000) immediately, with no clock edge needed.
  - Clock edges and write are ignored while reset is asserted.
- Reset release:
  - Deasserting reset does not change out.
  - The first capture happens at the next rising clk edge with write=1.
- Write:
  - At a rising clk edge with reset=0 and write=1, out takes the value of in.
  - Latency is 1 edge: the new value is visible after the edge and stays stable until the next qualifying edge or reset.
- Hold:
  - At a rising clk edge with write=0, out keeps its previous value.
  - Changes on in between edges have no effect on out.
- Simultaneous events: reset=1 coinciding with a clk edge and write=1 gives out = RESET_VALUE (reset dominates).
- Reset mid-operation: asserting reset between edges clears out at once; the clear does not wait for clk.
- Power-up before the first reset: out is undefined (X in simulation). Parents must assert reset before relying on out.
- Output path:
  - out is purely registered, with no combinational path from in or write to out.
  - Only the reset path to out is asynchronous.
- Structure:
  - Built as WIDTH instances of a 1-bit enable flip-flop cell: D-flop with async clear, plus a 2:1 hold/load mux selected by write.
  - Cells are generated per bit, with the bit index mapped one-to-one (in[i] goes to out[i]).
  - The per-bit reset value comes from RESET_VALUE[i]; a cell with a reset value of 1 uses an async-set variant.
- No bit manipulation: no sign or width conversion, no partial writes, no byte enables.

Test Plan:
- Assert reset=1 with no clock activity → out = 0x00000000 immediately; hold write=1 with in=0xFFFFFFFF across 2 edges → out stays 0x00000000.
- Release reset; set in=0x22100002, write=1; apply one rising edge → out = 0x22100002 after the edge, still 0x00000000 before it.
- Set write=0, in=0xDEADBEEF; apply 3 edges → out remains 0x22100002. Then write=1 with in=0x00000004; apply one edge → out = 0x00000004.
- With out=0x00000004, pulse reset high mid-cycle (between edges) → out = 0x00000000 without any clk edge. Release reset → value holds until the next write edge.
- Walking-ones check: write 1<<i for i=0..31 on consecutive edges → each out equals the written value exactly (no bit swaps). Also write 0xFFFFFFFF, then 0x00000000.
- Instantiate with RESET_VALUE=0x00400000 → reset yields out = 0x00400000; a subsequent write of 0x12345678 yields out = 0x12345678.

Source files
------------

// File: rtl/register_32.sv
// rtl/register_32.sv - 32-bit storage register with write enable and asynchronous clear
module register_32 #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h00000000
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in,
  input  logic             write,
  input  logic             reset,
  input  logic             clk
);

  // Reset value resized to the register width (truncated or zero-extended).
  localparam logic [WIDTH-1:0] resetBits = WIDTH'(RESET_VALUE);

  // One enable flop per bit, in[i] -> out[i]; bits that reset to 1 use the async-set cell.
  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    if (resetBits[i]) begin : gSet
      enableFlopSet u_cell (
        .q     (out[i]),
        .d     (in[i]),
        .load  (write),
        .preset(reset),
        .clk   (clk)
      );
    end else begin : gClr
      enableFlopClr u_cell (
        .q    (out[i]),
        .d    (in[i]),
        .load (write),
        .clear(reset),
        .clk  (clk)
      );
    end
  end

endmodule

// 1-bit enable flip-flop whose reset state is 0.
module enableFlopClr (
  output logic q,
  input  logic d,
  input  logic load,
  input  logic clear,
  input  logic clk
);

  // Async clear dominates; otherwise the hold/load mux feeds the flop.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) q <= 1'b0;
    else       q <= load ? d : q;
  end

endmodule

// 1-bit enable flip-flop whose reset state is 1.
module enableFlopSet (
  output logic q,
  input  logic d,
  input  logic load,
  input  logic preset,
  input  logic clk
);

  // Async set dominates; otherwise the hold/load mux feeds the flop.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) q <= 1'b1;
    else        q <= load ? d : q;
  end

endmodule

// File: tb/tb_register_32.sv
// tb/tb_register_32.sv - randomized self-checking bench for register_32
module tb_register_32;

  localparam logic [31:0] rstVal0 = 32'h00000000;
  localparam logic [31:0] rstVal1 = 32'h00400000;

  logic        clk;
  logic        reset;
  logic        write;
  logic [31:0] dataIn;
  logic [31:0] out0;
  logic [31:0] out1;

  // Reference model: the value each register should currently hold.
  logic [31:0] exp0;
  logic [31:0] exp1;

  int checkCnt;
  int errCnt;

  register_32 dutDefault (
    .out  (out0),
    .in   (dataIn),
    .write(write),
    .reset(reset),
    .clk  (clk)
  );

  register_32 #(.RESET_VALUE(rstVal1)) dutPreset (
    .out  (out1),
    .in   (dataIn),
    .write(write),
    .reset(reset),
    .clk  (clk)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCnt++;
    if (got !== want) begin
      errCnt++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic checkBoth(input string tag);
    checkVal({tag, "/d"}, out0, exp0);
    checkVal({tag, "/p"}, out1, exp1);
  endtask

  // One full clock period starting and ending with clk low; outputs sampled mid-high.
  task automatic tick(input string tag);
    clk = 1'b1;
    if (reset) begin
      exp0 = rstVal0;
      exp1 = rstVal1;
    end else if (write) begin
      exp0 = dataIn;
      exp1 = dataIn;
    end
    #2;
    checkBoth(tag);
    #3 clk = 1'b0;
    #5;
  endtask

  // Reset pulse between edges, checked before any clock activity.
  task automatic midReset(input string tag);
    #2 reset = 1'b1;
    exp0 = rstVal0;
    exp1 = rstVal1;
    #1 checkBoth(tag);
    reset = 1'b0;
    #1 checkBoth({tag, "-rel"});
  endtask

  initial begin
    checkCnt = 0;
    errCnt   = 0;
    clk      = 1'b0;
    reset    = 1'b0;
    write    = 1'b0;
    dataIn   = 32'h0;
    #3;

    // Reset with no clock activity.
    reset = 1'b1;
    exp0  = rstVal0;
    exp1  = rstVal1;
    #1 checkBoth("rstNoClk");
    write  = 1'b1;
    dataIn = 32'hFFFFFFFF;
    #6;
    tick("rstHold1");
    tick("rstHold2");

    // Release does not change the value; first write captures on the next edge.
    reset = 1'b0;
    #1 checkBoth("rstRelease");
    dataIn = 32'h22100002;
    write  = 1'b1;
    #1 checkBoth("preEdge");
    #3;
    tick("write1");

    // Hold for three edges while in changes.
    write  = 1'b0;
    dataIn = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) tick("hold");
    write  = 1'b1;
    dataIn = 32'h00000004;
    tick("write4");

    // Reset mid-cycle, then hold until the next write.
    write = 1'b0;
    midReset("midRst");
    tick("postRstHold");

    // Walking ones, then all ones and all zeros.
    write = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dataIn = 32'h1 << i;
      tick("walk");
    end
    dataIn = 32'hFFFFFFFF;
    tick("allOnes");
    dataIn = 32'h00000000;
    tick("allZeros");

    // Preset instance after reset, then an ordinary write.
    midReset("presetRst");
    dataIn = 32'h12345678;
    tick("presetWrite");

    // Reset coincident with a write edge: reset wins.
    dataIn = 32'hA5A5A5A5;
    reset  = 1'b1;
    tick("rstEdge");
    reset = 1'b0;
    #1;

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      dataIn = $urandom;
      write  = ($urandom_range(0, 2) != 0);
      reset  = ($urandom_range(0, 19) == 0);
      tick("rand");
      reset = 1'b0;
      dataIn = $urandom;
      #1 checkBoth("randInChg");
      if ($urandom_range(0, 15) == 0) midReset("randMidRst");
    end

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule
